// File: rtl/priority_scan_encoder.sv
// priority_scan_encoder: collects request bits into a pending register and
// drains them one index per cycle through a valid/ready output stage.
// The selection order is fixed-high, fixed-low or round-robin.
module priority_scan_encoder #(
  parameter int IN_DSIZE   = 16,
  parameter int OUT_DSIZE  = 4,
  parameter bit RR_MODE    = 1'b0,
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 req_valid_i,
  input  logic [IN_DSIZE-1:0]  req_i,
  input  logic                 out_ready_i,
  output logic                 out_valid_o,
  output logic [OUT_DSIZE-1:0] out_data_o,
  output logic [OUT_DSIZE:0]   pend_cnt_o,
  output logic                 idle_o
);

  localparam logic [OUT_DSIZE-1:0] PTR_INIT = OUT_DSIZE'(IN_DSIZE - 1);

  logic [IN_DSIZE-1:0]  pending;
  logic [IN_DSIZE-1:0]  above_mask;
  logic [IN_DSIZE-1:0]  masked;
  logic [IN_DSIZE-1:0]  grant_mask;
  logic [OUT_DSIZE-1:0] rr_ptr;
  logic [OUT_DSIZE-1:0] sel_idx;
  logic [OUT_DSIZE-1:0] out_data;
  logic [OUT_DSIZE:0]   pend_cnt;
  logic                 out_valid;
  logic                 slot_open;
  logic                 load;

  // Index of the lowest set bit; scanning downward so the lowest match lands last.
  function automatic logic [OUT_DSIZE-1:0] lowest_set(input logic [IN_DSIZE-1:0] vec);
    logic [OUT_DSIZE-1:0] idx;
    idx = '0;
    for (int i = IN_DSIZE - 1; i >= 0; i--) begin
      if (vec[i]) idx = OUT_DSIZE'(i);
    end
    return idx;
  endfunction

  // Index of the highest set bit; scanning upward so the highest match lands last.
  function automatic logic [OUT_DSIZE-1:0] highest_set(input logic [IN_DSIZE-1:0] vec);
    logic [OUT_DSIZE-1:0] idx;
    idx = '0;
    for (int i = 0; i < IN_DSIZE; i++) begin
      if (vec[i]) idx = OUT_DSIZE'(i);
    end
    return idx;
  endfunction

  // The stage may take a new index when empty or when its entry leaves this cycle.
  always_comb begin
    slot_open = !out_valid || out_ready_i;
    load      = slot_open && (pending != '0);
  end

  // Pick the next index: round-robin looks above the pointer first, then wraps to the bottom.
  always_comb begin
    above_mask = '0;
    for (int i = 0; i < IN_DSIZE; i++) begin
      above_mask[i] = (OUT_DSIZE'(i) > rr_ptr);
    end
    masked = pending & above_mask;
    if (RR_MODE) begin
      sel_idx = (masked != '0) ? lowest_set(masked) : lowest_set(pending);
    end else if (HIGH_FIRST) begin
      sel_idx = highest_set(pending);
    end else begin
      sel_idx = lowest_set(pending);
    end
  end

  // One-hot mask of the bit being handed to the output stage this cycle.
  always_comb begin
    grant_mask = '0;
    for (int i = 0; i < IN_DSIZE; i++) begin
      grant_mask[i] = load && (sel_idx == OUT_DSIZE'(i));
    end
  end

  // Pending, output stage and pointer; new requests are OR'd after the grant clears, so set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      rr_ptr    <= PTR_INIT;
    end else if (clear_i) begin
      pending   <= '0;
      out_valid <= 1'b0;
      rr_ptr    <= PTR_INIT;
    end else begin
      pending <= (pending & ~grant_mask) | (req_valid_i ? req_i : '0);
      if (load) begin
        out_data  <= sel_idx;
        out_valid <= 1'b1;
        rr_ptr    <= sel_idx;
      end else if (slot_open) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Population count of the pending register (output stage not included).
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < IN_DSIZE; i++) begin
      pend_cnt = pend_cnt + (OUT_DSIZE + 1)'(pending[i]);
    end
  end

  assign out_valid_o = out_valid;
  assign out_data_o  = out_data;
  assign pend_cnt_o  = pend_cnt;
  assign idle_o      = (pending == '0) && !out_valid;

endmodule

// File: tb/tb_priority_scan_encoder.sv
// tb_priority_scan_encoder: drives three encoder flavours (fixed-high,
// fixed-low, round-robin) with shared stimulus and compares each against a
// behavioural model of pending set, output stage and pointer.
module tb_priority_scan_encoder;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        req_valid;
  logic [15:0] req;
  logic        out_ready;

  logic        dut_valid [3];
  logic [3:0]  dut_data  [3];
  logic [4:0]  dut_cnt   [3];
  logic        dut_idle  [3];

  logic [15:0] m_pend  [3];
  bit          m_valid [3];
  int          m_data  [3];
  int          m_ptr   [3];

  string       inst_name [3] = '{"hi", "lo", "rr"};

  int cmp_count;
  int fail_count;

  priority_scan_encoder #(.IN_DSIZE(16), .OUT_DSIZE(4), .RR_MODE(1'b0), .HIGH_FIRST(1'b1)) dut_hi (
    .clk(clk), .rst(rst), .clear_i(clear), .req_valid_i(req_valid), .req_i(req),
    .out_ready_i(out_ready), .out_valid_o(dut_valid[0]), .out_data_o(dut_data[0]),
    .pend_cnt_o(dut_cnt[0]), .idle_o(dut_idle[0]));

  priority_scan_encoder #(.IN_DSIZE(16), .OUT_DSIZE(4), .RR_MODE(1'b0), .HIGH_FIRST(1'b0)) dut_lo (
    .clk(clk), .rst(rst), .clear_i(clear), .req_valid_i(req_valid), .req_i(req),
    .out_ready_i(out_ready), .out_valid_o(dut_valid[1]), .out_data_o(dut_data[1]),
    .pend_cnt_o(dut_cnt[1]), .idle_o(dut_idle[1]));

  priority_scan_encoder #(.IN_DSIZE(16), .OUT_DSIZE(4), .RR_MODE(1'b1), .HIGH_FIRST(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .clear_i(clear), .req_valid_i(req_valid), .req_i(req),
    .out_ready_i(out_ready), .out_valid_o(dut_valid[2]), .out_data_o(dut_data[2]),
    .pend_cnt_o(dut_cnt[2]), .idle_o(dut_idle[2]));

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int pickIndex(input int m);
    if (m == 2) begin
      for (int step = 1; step <= 16; step++) begin
        int idx;
        idx = (m_ptr[m] + step) % 16;
        if (m_pend[m][idx]) return idx;
      end
    end else if (m == 0) begin
      for (int i = 15; i >= 0; i--) if (m_pend[m][i]) return i;
    end else begin
      for (int i = 0; i < 16; i++) if (m_pend[m][i]) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 3; m++) begin
      m_pend[m]  = '0;
      m_valid[m] = 1'b0;
      m_data[m]  = 0;
      m_ptr[m]   = 15;
    end
  endtask

  task automatic modelStep(input bit clr, input bit rv, input logic [15:0] rq, input bit rdy);
    int g;
    for (int m = 0; m < 3; m++) begin
      if (clr) begin
        m_pend[m]  = '0;
        m_valid[m] = 1'b0;
        m_ptr[m]   = 15;
      end else begin
        g = -1;
        if (!m_valid[m] || rdy) begin
          if (m_pend[m] != 0) begin
            g          = pickIndex(m);
            m_data[m]  = g;
            m_valid[m] = 1'b1;
            m_ptr[m]   = g;
          end else begin
            m_valid[m] = 1'b0;
          end
        end
        if (g >= 0) m_pend[m][g] = 1'b0;
        if (rv) m_pend[m] = m_pend[m] | rq;
      end
    end
  endtask

  task automatic compareAll();
    for (int m = 0; m < 3; m++) begin
      checkOutput({inst_name[m], ".valid"}, 32'(dut_valid[m]), 32'(m_valid[m]));
      checkOutput({inst_name[m], ".data"},  32'(dut_data[m]),  m_data[m]);
      checkOutput({inst_name[m], ".cnt"},   32'(dut_cnt[m]),   $countones(m_pend[m]));
      checkOutput({inst_name[m], ".idle"},  32'(dut_idle[m]),  32'((m_pend[m] == 0) && !m_valid[m]));
    end
  endtask

  // Drives one cycle of inputs just after a falling edge, advances the model
  // across the following rising edge, and compares at the next falling edge.
  task automatic applyStimulus(input bit clr, input bit rv, input logic [15:0] rq, input bit rdy);
    clear     = clr;
    req_valid = rv;
    req       = rq;
    out_ready = rdy;
    modelStep(clr, rv, rq, rdy);
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    cmp_count  = 0;
    fail_count = 0;
    clk        = 1'b0;
    rst        = 1'b1;
    clear      = 1'b0;
    req_valid  = 1'b0;
    req        = '0;
    out_ready  = 1'b0;
    modelReset();

    repeat (2) @(negedge clk);
    compareAll();
    checkOutput("reset.idle", 32'(dut_idle[0]), 1);
    checkOutput("reset.cnt", 32'(dut_cnt[0]), 0);
    rst = 1'b0;

    // Fixed-high drain of 0x8421 with ready held high
    applyStimulus(1'b0, 1'b1, 16'h8421, 1'b1);
    checkOutput("t1.cnt_loaded", 32'(dut_cnt[0]), 4);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t1.first", 32'(dut_data[0]), 15);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t1.second", 32'(dut_data[0]), 10);
    checkOutput("t1.lo_second", 32'(dut_data[1]), 5);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t1.third", 32'(dut_data[0]), 5);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t1.fourth", 32'(dut_data[0]), 0);
    checkOutput("t1.fourth_valid", 32'(dut_valid[0]), 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t1.done_valid", 32'(dut_valid[0]), 0);
    checkOutput("t1.done_idle", 32'(dut_idle[0]), 1);

    // Backpressure: output holds at 15 while ready is low
    applyStimulus(1'b0, 1'b1, 16'h8421, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
      checkOutput("t2.held", 32'(dut_data[0]), 15);
      checkOutput("t2.held_cnt", 32'(dut_cnt[0]), 3);
    end
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t2.after1", 32'(dut_data[0]), 10);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t2.after2", 32'(dut_data[0]), 5);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t2.after3", 32'(dut_data[0]), 0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);

    // Round-robin: a re-request of bit 0 must not starve bit 7
    applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0081, 1'b1);
    applyStimulus(1'b0, 1'b1, 16'h0001, 1'b1);
    checkOutput("t3.rr_first", 32'(dut_data[2]), 0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t3.rr_second", 32'(dut_data[2]), 7);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t3.rr_third", 32'(dut_data[2]), 0);
    checkOutput("t3.rr_valid", 32'(dut_valid[2]), 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);

    // Set wins over clear for a bit re-requested in its grant cycle
    applyStimulus(1'b0, 1'b1, 16'h0008, 1'b1);
    checkOutput("t4.cnt_before", 32'(dut_cnt[0]), 1);
    applyStimulus(1'b0, 1'b1, 16'h0008, 1'b1);
    checkOutput("t4.first", 32'(dut_data[0]), 3);
    checkOutput("t4.cnt_kept", 32'(dut_cnt[0]), 1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t4.second", 32'(dut_data[0]), 3);
    checkOutput("t4.second_valid", 32'(dut_valid[0]), 1);
    checkOutput("t4.cnt_after", 32'(dut_cnt[0]), 0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);

    // clear overrides a simultaneous full load while the stage is occupied
    applyStimulus(1'b0, 1'b1, 16'h8421, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 1'b1);
    checkOutput("t5.valid", 32'(dut_valid[0]), 0);
    checkOutput("t5.idle", 32'(dut_idle[0]), 1);
    checkOutput("t5.cnt", 32'(dut_cnt[0]), 0);
    checkOutput("t5.data_kept", 32'(dut_data[0]), 15);

    // Asynchronous reset mid-drain with five requests pending
    applyStimulus(1'b0, 1'b1, 16'h003F, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("t6.cnt_pre", 32'(dut_cnt[0]), 5);
    #2 rst = 1'b1;
    modelReset();
    #1;
    checkOutput("t6.async_valid", 32'(dut_valid[0]), 0);
    checkOutput("t6.async_data", 32'(dut_data[0]), 0);
    checkOutput("t6.async_cnt", 32'(dut_cnt[0]), 0);
    checkOutput("t6.async_idle", 32'(dut_idle[0]), 1);
    compareAll();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 16'h0003, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t6.rr_after_reset", 32'(dut_data[2]), 0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("t6.rr_next", 32'(dut_data[2]), 1);

    // Randomised traffic across all three flavours
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(0, 31) == 0), ($urandom_range(0, 2) == 0),
                    16'($urandom), ($urandom_range(0, 9) < 7));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
